secuenciador_registros: RTL and testbench

Command-driven bus sequencer that sits directly upstream of the register bank and owns its RD, WR, SEL and the shared 16-bit tristate DATA bus. It accepts one register-transfer command at a time over a valid/ready handshake: load immediate, read, move, exchange. It expands each command into single-cycle bank read/write bus cycles, and returns a one-cycle response carrying the transferred value.

---
 rtl/secuenciador_registros.sv | 160 ++++++++++++++++
 tb/tb_secuenciador_registros.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_registros.sv
// Command-driven sequencer that expands register-transfer commands into single-cycle
// bank read/write cycles on a shared tristate DATA bus and returns a one-cycle response.
module secuenciador_registros (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [3:0]  CMD_SRC,
    input  logic [3:0]  CMD_DST,
    input  logic [15:0] CMD_IMM,
    output logic        RSP_VALID,
    output logic [15:0] RSP_DATA,
    output logic        RD,
    output logic        WR,
    output logic [3:0]  SEL,
    inout  wire  [15:0] DATA
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRdA  = 3'd1;
    localparam logic [2:0] StRdB  = 3'd2;
    localparam logic [2:0] StWrA  = 3'd3;
    localparam logic [2:0] StWrB  = 3'd4;
    localparam logic [2:0] StDone = 3'd5;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpRead = 2'b01;
    localparam logic [1:0] OpMov  = 2'b10;
    localparam logic [1:0] OpXchg = 2'b11;

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  src_q, src_d;
    logic [3:0]  dst_q, dst_d;
    logic [15:0] imm_q, imm_d;
    logic [15:0] t0_q, t0_d;
    logic [15:0] t1_q, t1_d;
    logic [15:0] rsp_data_q, rsp_data_d;

    logic        rd_en;
    logic        wr_en;
    logic [3:0]  sel;
    logic [15:0] dout;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            op_q       <= OpLoad;
            src_q      <= 4'd0;
            dst_q      <= 4'd0;
            imm_q      <= 16'd0;
            t0_q       <= 16'd0;
            t1_q       <= 16'd0;
            rsp_data_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src_d      = src_q;
        dst_d      = dst_q;
        imm_d      = imm_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    op_d    = CMD_OP;
                    src_d   = CMD_SRC;
                    dst_d   = CMD_DST;
                    imm_d   = CMD_IMM;
                    state_d = (CMD_OP == OpLoad) ? StWrA : StRdA;
                end
            end
            StRdA: begin
                t0_d = DATA;
                case (op_q)
                    OpMov:   state_d = StWrA;
                    OpXchg:  state_d = StRdB;
                    default: begin
                        rsp_data_d = DATA;
                        state_d    = StDone;
                    end
                endcase
            end
            StRdB: begin
                t1_d    = DATA;
                state_d = StWrA;
            end
            StWrA: begin
                if (op_q == OpXchg) begin
                    state_d = StWrB;
                end else begin
                    rsp_data_d = (op_q == OpLoad) ? imm_q : t0_q;
                    state_d    = StDone;
                end
            end
            StWrB: begin
                rsp_data_d = t0_q;
                state_d    = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus controls decode only registered state, so CMD_* never reaches the bus directly.
    always_comb begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        sel   = 4'd0;
        dout  = 16'd0;
        case (state_q)
            StRdA: begin
                rd_en = 1'b1;
                sel   = src_q;
            end
            StRdB: begin
                rd_en = 1'b1;
                sel   = dst_q;
            end
            StWrA: begin
                wr_en = 1'b1;
                if (op_q == OpXchg) begin
                    sel  = src_q;
                    dout = t1_q;
                end else begin
                    sel  = dst_q;
                    dout = (op_q == OpLoad) ? imm_q : t0_q;
                end
            end
            StWrB: begin
                wr_en = 1'b1;
                sel   = dst_q;
                dout  = t0_q;
            end
            default: ;
        endcase
    end

    assign RD        = rd_en;
    assign WR        = wr_en;
    assign SEL       = sel;
    assign DATA      = wr_en ? dout : 16'hzzzz;
    assign CMD_READY = (state_q == StIdle);
    assign RSP_VALID = (state_q == StDone);
    assign RSP_DATA  = rsp_data_q;

endmodule

// File: tb/tb_secuenciador_registros.sv
// Bench for secuenciador_registros: behavioural register bank on DATA plus a
// register-file reference model predicting bus cycles, responses and bank contents.
module tb_secuenciador_registros;

    logic        CLK;
    logic        RST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [3:0]  CMD_SRC;
    logic [3:0]  CMD_DST;
    logic [15:0] CMD_IMM;
    logic        RSP_VALID;
    logic [15:0] RSP_DATA;
    logic        RD;
    logic        WR;
    logic [3:0]  SEL;
    wire  [15:0] DATA;

    int tests = 0;
    int fails = 0;
    int bus_viol = 0;
    int last_wait = 0;
    logic [15:0] prev_rsp = 16'h0000;

    // Index 0-7: AX,CX,DX,BX,SP,BP,SI,DI.
    logic [7:0][15:0] bank = '0;
    logic [7:0][15:0] mreg = '0;

    secuenciador_registros dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_SRC   (CMD_SRC),
        .CMD_DST   (CMD_DST),
        .CMD_IMM   (CMD_IMM),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .RD        (RD),
        .WR        (WR),
        .SEL       (SEL),
        .DATA      (DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] mread(input logic [7:0][15:0] r, input logic [3:0] s);
        if (s < 4'd4) return {8'h00, r[s[1:0]][7:0]};
        else if (s < 4'd8) return {8'h00, r[s[1:0]][15:8]};
        else return r[s[2:0]];
    endfunction

    function automatic logic [7:0][15:0] mwrite(input logic [7:0][15:0] r, input logic [3:0] s,
                                                input logic [15:0] v);
        logic [7:0][15:0] n;
        n = r;
        if (s < 4'd4) n[s[1:0]][7:0] = v[7:0];
        else if (s < 4'd8) n[s[1:0]][15:8] = v[7:0];
        else n[s[2:0]] = v;
        return n;
    endfunction

    assign DATA = (RD === 1'b1) ? mread(bank, SEL) : 16'hzzzz;
    always @(posedge CLK) if (WR === 1'b1) bank <= mwrite(bank, SEL, DATA);
    always @(negedge CLK) if (RD === 1'b1 && WR === 1'b1) bus_viol++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge inside the DONE cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                          input logic [15:0] imm, output logic [15:0] rsp);
        logic [15:0] v0, v1, exp_rsp;
        logic [3:0]  s[4];
        logic        r[4];
        logic        w[4];
        logic [15:0] d[4];
        int          n;
        int          waited;
        v0 = mread(mreg, src);
        v1 = mread(mreg, dst);
        exp_rsp = v0;
        case (op)
            2'b00: begin
                n = 1; exp_rsp = imm;
                r[0] = 0; w[0] = 1; s[0] = dst; d[0] = imm;
            end
            2'b01: begin
                n = 1;
                r[0] = 1; w[0] = 0; s[0] = src; d[0] = v0;
            end
            2'b10: begin
                n = 2;
                r[0] = 1; w[0] = 0; s[0] = src; d[0] = v0;
                r[1] = 0; w[1] = 1; s[1] = dst; d[1] = v0;
            end
            default: begin
                n = 4;
                r[0] = 1; w[0] = 0; s[0] = src; d[0] = v0;
                r[1] = 1; w[1] = 0; s[1] = dst; d[1] = v1;
                r[2] = 0; w[2] = 1; s[2] = src; d[2] = v1;
                r[3] = 0; w[3] = 1; s[3] = dst; d[3] = v0;
            end
        endcase
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_SRC   = src;
        CMD_DST   = dst;
        CMD_IMM   = imm;
        waited    = 0;
        while (CMD_READY !== 1'b1 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        last_wait = waited;
        rsp = RSP_DATA;
        if (CMD_READY !== 1'b1) begin
            check("accept_timeout", {31'b0, CMD_READY}, 32'd1);
            CMD_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'($urandom);
        CMD_SRC   = 4'($urandom);
        CMD_DST   = 4'($urandom);
        CMD_IMM   = 16'($urandom);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            check($sformatf("bus_cycle%0d_op%0d", k, op),
                  {8'h0, RSP_VALID, CMD_READY, RD, WR, SEL, DATA},
                  {8'h0, 1'b0, 1'b0, r[k], w[k], s[k], d[k]});
            check("rsp_hold", {16'h0, RSP_DATA}, {16'h0, prev_rsp});
        end
        @(negedge CLK);
        check($sformatf("done_ctrl_op%0d", op), {26'h0, RSP_VALID, CMD_READY, RD, WR, SEL},
              {26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        check($sformatf("rsp_data_op%0d", op), {16'h0, RSP_DATA}, {16'h0, exp_rsp});
        rsp = RSP_DATA;
        prev_rsp = exp_rsp;
        for (int k = 0; k < n; k++) if (w[k]) mreg = mwrite(mreg, s[k], d[k]);
    endtask

    logic [15:0] rsp;

    initial begin
        RST       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'b00;
        CMD_SRC   = 4'd0;
        CMD_DST   = 4'd0;
        CMD_IMM   = 16'd0;
        @(negedge CLK);
        check("reset_ctrl", {26'h0, RSP_VALID, CMD_READY, RD, WR, SEL},
              {26'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        check("reset_rsp_data", {16'h0, RSP_DATA}, 32'h0);
        RST = 1'b0;

        // LOAD AX then READ AX
        do_cmd(2'b00, 4'd0, 4'd8, 16'h1234, rsp);
        do_cmd(2'b01, 4'd8, 4'd0, 16'h0000, rsp);
        check("read_ax", {16'h0, rsp}, 32'h1234);

        // LOAD SP, MOV SP->DI, READ DI
        do_cmd(2'b00, 4'd0, 4'd12, 16'hBEEF, rsp);
        do_cmd(2'b10, 4'd12, 4'd15, 16'h0000, rsp);
        check("mov_rsp", {16'h0, rsp}, 32'hBEEF);
        do_cmd(2'b01, 4'd15, 4'd0, 16'h0000, rsp);
        check("read_di", {16'h0, rsp}, 32'hBEEF);

        // XCHG SI/BP
        do_cmd(2'b00, 4'd0, 4'd14, 16'h1111, rsp);
        do_cmd(2'b00, 4'd0, 4'd13, 16'h2222, rsp);
        do_cmd(2'b11, 4'd14, 4'd13, 16'h0000, rsp);
        check("xchg_rsp", {16'h0, rsp}, 32'h1111);
        do_cmd(2'b01, 4'd14, 4'd0, 16'h0000, rsp);
        check("read_si", {16'h0, rsp}, 32'h2222);
        do_cmd(2'b01, 4'd13, 4'd0, 16'h0000, rsp);
        check("read_bp", {16'h0, rsp}, 32'h1111);

        // Byte views of AX
        do_cmd(2'b00, 4'd0, 4'd8, 16'hABCD, rsp);
        do_cmd(2'b01, 4'd0, 4'd0, 16'h0000, rsp);
        check("read_al", {16'h0, rsp}, 32'h00CD);
        do_cmd(2'b01, 4'd4, 4'd0, 16'h0000, rsp);
        check("read_ah", {16'h0, rsp}, 32'h00AB);

        // Four commands presented during DONE: each waits exactly one cycle
        do_cmd(2'b00, 4'd0, 4'd9, 16'h5A5A, rsp);
        check("b2b_wait0", last_wait, 32'd1);
        do_cmd(2'b10, 4'd9, 4'd10, 16'h0000, rsp);
        check("b2b_wait1", last_wait, 32'd1);
        do_cmd(2'b11, 4'd10, 4'd8, 16'h0000, rsp);
        check("b2b_wait2", last_wait, 32'd1);
        do_cmd(2'b01, 4'd8, 4'd0, 16'h0000, rsp);
        check("b2b_wait3", last_wait, 32'd1);

        // Reset while the second XCHG write is on the bus
        do_cmd(2'b00, 4'd0, 4'd14, 16'h5555, rsp);
        do_cmd(2'b00, 4'd0, 4'd13, 16'h6666, rsp);
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b11;
        CMD_SRC   = 4'd14;
        CMD_DST   = 4'd13;
        for (int i = 0; i < 20 && CMD_READY !== 1'b1; i++) @(negedge CLK);
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        check("abort_wr_b", {26'h0, RD, WR, SEL}, {26'h0, 1'b0, 1'b1, 4'd13});
        #1;
        RST = 1'b1;
        #1;
        check("abort_ctrl", {26'h0, RSP_VALID, CMD_READY, RD, WR, SEL},
              {26'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        check("abort_rsp_data", {16'h0, RSP_DATA}, 32'h0);
        mreg = mwrite(mreg, 4'd14, 16'h6666);
        prev_rsp = 16'h0000;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("abort_release", {30'h0, RSP_VALID, CMD_READY}, {30'h0, 1'b0, 1'b1});
        do_cmd(2'b01, 4'd14, 4'd0, 16'h0000, rsp);
        check("abort_si", {16'h0, rsp}, 32'h6666);
        do_cmd(2'b01, 4'd13, 4'd0, 16'h0000, rsp);
        check("abort_bp", {16'h0, rsp}, 32'h6666);

        // Random commands against the model, including overlapping and equal selects
        for (int i = 0; i < 24; i++) begin
            do_cmd(2'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), rsp);
        end

        @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bank_reg%0d", i), {16'h0, bank[i]}, {16'h0, mreg[i]});
        end
        check("rd_wr_exclusive", bus_viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
